// File: rtl/pwm_led_pkg.sv
// Shared register map, CTRL layout and byte-lane helper for the PWM LED controller.
package pwm_led_pkg;

  // Word offsets, i.e. device_addr_i[7:2]
  localparam logic [5:0] DUTY_BASE       = 6'h00;
  localparam logic [5:0] CTRL_OFFSET     = 6'h10;
  localparam logic [5:0] PRESCALE_OFFSET = 6'h11;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_INV_BIT = 1;

  typedef struct packed {
    logic inv;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/pwm_led_prescaler.sv
// Reload down-counter: tick_o while the count is zero, held at zero when disabled.
module pwm_led_prescaler
  import pwm_led_pkg::*;
#(
  parameter int PrescaleWidth = 16
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_sys_i,
  input  logic                     en_i,
  input  logic [PrescaleWidth-1:0] reload_i,
  output logic                     tick_o
);

  logic [PrescaleWidth-1:0] cnt_q;

  // Reload value is sampled only at terminal count, so a new PRESCALE never cuts a countdown short.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      cnt_q <= '0;
    end else if (!en_i) begin
      cnt_q <= '0;
    end else if (cnt_q == '0) begin
      cnt_q <= reload_i;
    end else begin
      cnt_q <= cnt_q - PrescaleWidth'(1);
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/pwm_led_ctrl.sv
// Memory-mapped per-channel PWM LED controller with single-cycle request/rvalid bus.
// Define PWM_LED_SHADOW_EN to double-buffer DUTY so changes land only at period wrap.
module pwm_led_ctrl
  import pwm_led_pkg::*;
#(
  parameter int NumChannels   = 12,
  parameter int CtrWidth      = 8,
  parameter int PrescaleWidth = 16
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_i,
  input  logic                   device_req_i,
  input  logic [31:0]            device_addr_i,
  input  logic                   device_we_i,
  input  logic [3:0]             device_be_i,
  input  logic [31:0]            device_wdata_i,
  output logic                   device_rvalid_o,
  output logic [31:0]            device_rdata_o,
  output logic [NumChannels-1:0] pwm_o
);

  localparam logic [CtrWidth-1:0] CtrMax = {{(CtrWidth-1){1'b1}}, 1'b0};

  logic [5:0]               word_addr;
  logic                     wr_en;
  logic                     rd_en;
  logic [31:0]              be_mask;
  ctrl_t                    ctrl_q;
  logic [PrescaleWidth-1:0] prescale_q;
  logic [CtrWidth-1:0]      duty_active_q [NumChannels];
  logic [CtrWidth-1:0]      duty_rd [NumChannels];
  logic [NumChannels-1:0]   duty_we;
  logic [CtrWidth-1:0]      ctr_q;
  logic                     tick;
  logic                     wrap;
  logic [NumChannels-1:0]   pwm_q;
  logic                     rvalid_q;
  logic [31:0]              rdata_q;
  logic [31:0]              rdata_d;
  logic                     unused_bus;

  assign word_addr = device_addr_i[7:2];
  assign wr_en     = device_req_i && device_we_i;
  assign rd_en     = device_req_i && !device_we_i;
  assign be_mask   = be_to_mask(device_be_i);
  assign unused_bus = ^{device_addr_i[31:8], device_addr_i[1:0],
                        device_wdata_i[31:PrescaleWidth], be_mask[31:PrescaleWidth]};

  always_comb begin
    duty_we = '0;
    for (int n = 0; n < NumChannels; n++) begin
      duty_we[n] = wr_en && device_be_i[0] && (word_addr == DUTY_BASE + 6'(n));
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
    end else if (wr_en) begin
      if (word_addr == CTRL_OFFSET && device_be_i[0]) begin
        ctrl_q.en  <= device_wdata_i[CTRL_EN_BIT];
        ctrl_q.inv <= device_wdata_i[CTRL_INV_BIT];
      end
      if (word_addr == PRESCALE_OFFSET) begin
        prescale_q <= (prescale_q & ~be_mask[PrescaleWidth-1:0]) |
                      (device_wdata_i[PrescaleWidth-1:0] & be_mask[PrescaleWidth-1:0]);
      end
    end
  end

`ifdef PWM_LED_SHADOW_EN
  logic [CtrWidth-1:0] duty_pending_q [NumChannels];

  // While disabled there is no period to glitch, so active tracks pending and enabling starts clean.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      for (int n = 0; n < NumChannels; n++) begin
        duty_pending_q[n] <= '0;
        duty_active_q[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < NumChannels; n++) begin
        if (duty_we[n]) duty_pending_q[n] <= device_wdata_i[CtrWidth-1:0];
        if (wrap || !ctrl_q.en) duty_active_q[n] <= duty_pending_q[n];
      end
    end
  end

  assign duty_rd = duty_pending_q;
`else
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      for (int n = 0; n < NumChannels; n++) duty_active_q[n] <= '0;
    end else begin
      for (int n = 0; n < NumChannels; n++) begin
        if (duty_we[n]) duty_active_q[n] <= device_wdata_i[CtrWidth-1:0];
      end
    end
  end

  assign duty_rd = duty_active_q;
`endif

  pwm_led_prescaler #(
    .PrescaleWidth(PrescaleWidth)
  ) u_prescaler (
    .clk_sys_i(clk_sys_i),
    .rst_sys_i(rst_sys_i),
    .en_i     (ctrl_q.en),
    .reload_i (prescale_q),
    .tick_o   (tick)
  );

  // Period is 2^CtrWidth-1 ticks so that the full-scale duty value is a steady high.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      ctr_q <= '0;
    end else if (!ctrl_q.en) begin
      ctr_q <= '0;
    end else if (tick) begin
      ctr_q <= (ctr_q == CtrMax) ? '0 : ctr_q + CtrWidth'(1);
    end
  end

  assign wrap = tick && (ctr_q == CtrMax);

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      pwm_q <= '0;
    end else begin
      for (int n = 0; n < NumChannels; n++) begin
        pwm_q[n] <= ctrl_q.inv ^ (ctrl_q.en && (ctr_q < duty_active_q[n]));
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (word_addr == CTRL_OFFSET) begin
      rdata_d[1:0] = ctrl_q;
    end else if (word_addr == PRESCALE_OFFSET) begin
      rdata_d[PrescaleWidth-1:0] = prescale_q;
    end else begin
      for (int n = 0; n < NumChannels; n++) begin
        if (word_addr == DUTY_BASE + 6'(n)) rdata_d[CtrWidth-1:0] = duty_rd[n];
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= device_req_i;
      rdata_q  <= rd_en ? rdata_d : '0;
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign pwm_o           = pwm_q;

endmodule

// File: tb/tb_pwm_led_ctrl.sv
// Directed bench for pwm_led_ctrl: register-access vector table plus multi-cycle PWM sequences.
module tb_pwm_led_ctrl;

  localparam int NV = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic [11:0] pwm;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [NV];

  pwm_led_ctrl dut (
    .clk_sys_i      (clk),
    .rst_sys_i      (rst),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .pwm_o          (pwm)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit, expected finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] b, input logic [31:0] e);
    vec_t v;
    v.addr = a; v.we = w; v.wdata = d; v.be = b; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    @(negedge clk);
    check("wr_rvalid", 32'(rvalid), 32'd1);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
    @(negedge clk);
    check("rd_rvalid", 32'(rvalid), 32'd1);
    check($sformatf("rd_data_%0h", a), rdata, e);
    req = 1'b0;
  endtask

  task automatic check_resp(input int j);
    check($sformatf("tbl%0d_rvalid", j), 32'(rvalid), 32'd1);
    if (!tbl[j].we) check($sformatf("tbl%0d_rdata", j), rdata, tbl[j].exp);
  endtask

  initial begin
    int mis, hi1, hi2, dnew;
    bit e0;

    tbl[0]  = mk(32'h00, 1'b0, 32'h0,         4'hF, 32'h0);
    tbl[1]  = mk(32'h40, 1'b0, 32'h0,         4'hF, 32'h0);
    tbl[2]  = mk(32'h44, 1'b0, 32'h0,         4'hF, 32'h0);
    tbl[3]  = mk(32'h2C, 1'b0, 32'h0,         4'hF, 32'h0);
    tbl[4]  = mk(32'h44, 1'b1, 32'h0000_0100, 4'b0010, 32'h0);
    tbl[5]  = mk(32'h44, 1'b0, 32'h0,         4'hF, 32'h100);
    tbl[6]  = mk(32'h44, 1'b1, 32'h0000_ABCD, 4'b0001, 32'h0);
    tbl[7]  = mk(32'h44, 1'b0, 32'h0,         4'hF, 32'h1CD);
    tbl[8]  = mk(32'h04, 1'b1, 32'hFFFF_FF5A, 4'b0001, 32'h0);
    tbl[9]  = mk(32'h04, 1'b0, 32'h0,         4'hF, 32'h5A);
    tbl[10] = mk(32'h08, 1'b1, 32'h0000_0077, 4'b1110, 32'h0);
    tbl[11] = mk(32'h08, 1'b0, 32'h0,         4'hF, 32'h0);
    tbl[12] = mk(32'h80, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0);
    tbl[13] = mk(32'h80, 1'b0, 32'h0,         4'hF, 32'h0);
    tbl[14] = mk(32'h40, 1'b1, 32'hFFFF_FFFE, 4'hF, 32'h0);
    tbl[15] = mk(32'h40, 1'b0, 32'h0,         4'hF, 32'h2);
    tbl[16] = mk(32'h30, 1'b1, 32'h0000_00FF, 4'hF, 32'h0);
    tbl[17] = mk(32'h30, 1'b0, 32'h0,         4'hF, 32'h0);
    tbl[18] = mk(32'h44, 1'b1, 32'h0,         4'hF, 32'h0);
    tbl[19] = mk(32'h44, 1'b0, 32'h0,         4'hF, 32'h0);

    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;

    // Back-to-back requests, one per cycle; each response checked one cycle later.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (i > 0) check_resp(i - 1);
      req = 1'b1; we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata; be = tbl[i].be;
    end
    @(negedge clk);
    check_resp(NV - 1);
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    check("idle_rvalid", 32'(rvalid), 32'h0);
    check("disabled_inv_pwm", 32'(pwm), 32'hFFF);
    bus_write(32'h40, 32'h0, 4'hF);
    @(negedge clk);
    check("disabled_pwm", 32'(pwm), 32'h0);

    // DUTY[0]=64, prescale 0: high for 64 of every 255 cycles
    bus_write(32'h00, 32'd64, 4'h1);
    bus_write(32'h40, 32'h1, 4'h1);
    mis = 0; hi1 = 0; hi2 = 0;
    for (int k = 1; k <= 510; k++) begin
      @(negedge clk);
      e0 = ((k - 1) % 255) < 64;
      if (pwm[0] !== e0) mis++;
      if (pwm[0] === 1'b1) begin
        if (k <= 255) hi1++; else hi2++;
      end
    end
    check("pwm0_shape", 32'(mis), 32'd0);
    check("pwm0_high_p1", 32'(hi1), 32'd64);
    check("pwm0_high_p2", 32'(hi2), 32'd64);

    // DUTY[1]=0, DUTY[2]=255 with INV
    bus_write(32'h40, 32'h0, 4'h1);
    bus_write(32'h04, 32'd0, 4'h1);
    bus_write(32'h08, 32'd255, 4'h1);
    bus_write(32'h40, 32'h3, 4'h1);
    mis = 0; hi1 = 0; hi2 = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      e0 = !(((k - 1) % 255) < 64);
      if (pwm[0] !== e0) mis++;
      if (pwm[1] !== 1'b1) hi1++;
      if (pwm[2] !== 1'b0) hi2++;
    end
    check("inv_pwm0_shape", 32'(mis), 32'd0);
    check("inv_duty0_pwm1_bad", 32'(hi1), 32'd0);
    check("inv_duty255_pwm2_bad", 32'(hi2), 32'd0);

    // DUTY[0] 64 -> 128 written so it lands at ctr=100
    bus_write(32'h40, 32'h0, 4'h1);
    bus_write(32'h00, 32'd64, 4'h1);
    bus_write(32'h40, 32'h1, 4'h1);
`ifdef PWM_LED_SHADOW_EN
    dnew = 256;
`else
    dnew = 101;
`endif
    mis = 0; hi1 = 0; hi2 = 0;
    for (int k = 1; k <= 510; k++) begin
      @(negedge clk);
      e0 = ((k - 1) % 255) < ((k >= dnew) ? 128 : 64);
      if (pwm[0] !== e0) mis++;
      if (pwm[0] === 1'b1) begin
        if (k <= 255) hi1++; else hi2++;
      end
      if (k == 100) begin
        check("mid_wr_rvalid", 32'(rvalid), 32'd1);
        req = 1'b0; we = 1'b0;
      end
      if (k == 99) begin
        req = 1'b1; we = 1'b1; addr = 32'h00; wdata = 32'd128; be = 4'h1;
      end
    end
    check("mid_change_shape", 32'(mis), 32'd0);
`ifdef PWM_LED_SHADOW_EN
    check("mid_change_high_p1", 32'(hi1), 32'd64);
`else
    check("mid_change_high_p1", 32'(hi1), 32'd92);
`endif
    check("mid_change_high_p2", 32'(hi2), 32'd128);

    // PRESCALE=3: counter steps every 4th cycle
    bus_write(32'h40, 32'h0, 4'h1);
    bus_write(32'h44, 32'd3, 4'hF);
    bus_write(32'h00, 32'd2, 4'h1);
    bus_write(32'h40, 32'h1, 4'h1);
    mis = 0; hi1 = 0;
    for (int k = 1; k <= 1030; k++) begin
      @(negedge clk);
      e0 = (((k + 2) / 4) % 255) < 2;
      if (pwm[0] !== e0) mis++;
      if (pwm[0] === 1'b1) hi1++;
    end
    check("presc3_shape", 32'(mis), 32'd0);
    check("presc3_highs", 32'(hi1), 32'd13);
    check("presc3_pwm2_on", 32'(pwm[2]), 32'd1);

    // Reset mid-period while enabled
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pwm", 32'(pwm), 32'h0);
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    rst = 1'b0;
    bus_read(32'h00, 32'h0);
    bus_read(32'h08, 32'h0);
    bus_read(32'h40, 32'h0);
    bus_read(32'h44, 32'h0);
    bus_write(32'h80, 32'h1234_5678, 4'hF);
    bus_read(32'h80, 32'h0);
    repeat (4) @(negedge clk);
    check("post_rst_pwm", 32'(pwm), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
